// File: rtl/cpri_rom_play_ctrl.sv
// CPRI test-pattern ROM playback sequencer: chip-grid align, symbol walk,
// read-valid pipeline, SOP strobe and drain/done handshake.
// Ports: clk, rst_n (sync, active-low), start_i, stop_i -> busy_o,
//   rd_en_o, rd_addr_o, vld_o, sym_idx_o, sym_start_o, sop_o, done_o.
// Build option: define CPRI_PLAY_LOOP_EN to replay periods until stop_i.
module cpri_rom_play_ctrl #(
  parameter int ADDR_DW    = 16,
  parameter int SYM_LEN    = 12672,
  parameter int SYM_PERIOD = 5,
  parameter int ACT_SYM    = 1,
  parameter int CHIP_LEN   = 96,
  parameter int SOP_OFS    = 3,
  parameter int RD_LAT     = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic               stop_i,
  output logic               busy_o,
  output logic               rd_en_o,
  output logic [ADDR_DW-1:0] rd_addr_o,
  output logic               vld_o,
  output logic [2:0]         sym_idx_o,
  output logic               sym_start_o,
  output logic               sop_o,
  output logic               done_o
);

  localparam int CW = $clog2(CHIP_LEN + 1);
  localparam int DW = $clog2(RD_LAT + 1);

  localparam logic [CW-1:0]      CHIP_LAST = CW'(CHIP_LEN - 1);
  localparam logic [CW-1:0]      SOP_AT    = CW'(SOP_OFS);
  localparam logic [ADDR_DW-1:0] ADDR_LAST = ADDR_DW'(SYM_LEN - 1);
  localparam logic [2:0]         SYM_LAST  = 3'(SYM_PERIOD - 1);
  localparam logic [3:0]         ACT_N     = 4'(ACT_SYM);
  localparam logic [DW-1:0]      DRN_LAST  = DW'(RD_LAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ALIGN,
    PLAY,
    DRAIN
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        chip_q, chip_d;
  logic [ADDR_DW-1:0]   addr_q, addr_d;
  logic [2:0]           sym_q, sym_d;
  logic                 stop_pend_q, stop_pend_d;
  logic [DW-1:0]        drn_q, drn_d;

  logic                 rd_en_q, rd_en_d;
  logic [ADDR_DW-1:0]   rd_addr_q, rd_addr_d;
  logic [2:0]           sym_idx_q, sym_idx_d;
  logic                 sym_start_q, sym_start_d;
  logic                 sop_q, done_q, done_d;
  logic [RD_LAT-1:0]    vld_sr_q;

  logic sym_end, per_end, stop_now;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    sym_d       = sym_q;
    stop_pend_d = stop_pend_q;
    drn_d       = drn_q;
    chip_d      = (chip_q == CHIP_LAST) ? '0 : chip_q + CW'(1);
    sym_end     = (addr_q == ADDR_LAST);
    per_end     = sym_end && (sym_q == SYM_LAST);
    // a stop seen on the last word of a symbol ends that same symbol
    stop_now    = stop_pend_q | stop_i;

    unique case (state_q)
      IDLE: begin
        if (start_i && !stop_i) state_d = ALIGN;
      end
      ALIGN: begin
        if (stop_i) begin
          state_d = IDLE;
        end else if (chip_q == CHIP_LAST) begin
          state_d     = PLAY;
          addr_d      = '0;
          sym_d       = '0;
          stop_pend_d = 1'b0;
        end
      end
      PLAY: begin
        if (stop_i) stop_pend_d = 1'b1;
        if (sym_end) begin
          addr_d = '0;
          if (stop_now) begin
            state_d = DRAIN;
            drn_d   = '0;
          end else if (per_end) begin
`ifdef CPRI_PLAY_LOOP_EN
            sym_d = '0;
`else
            state_d = DRAIN;
            drn_d   = '0;
`endif
          end else begin
            sym_d = sym_q + 3'd1;
          end
        end else begin
          addr_d = addr_q + ADDR_DW'(1);
        end
      end
      DRAIN: begin
        if (drn_q == DRN_LAST) state_d = IDLE;
        else drn_d = drn_q + DW'(1);
      end
      default: state_d = IDLE;
    endcase

    // outputs are registered from next-state so they align with state_q
    rd_en_d     = (state_d == PLAY) && ({1'b0, sym_d} < ACT_N);
    rd_addr_d   = rd_en_d ? addr_d : '0;
    sym_idx_d   = (state_d == PLAY) ? sym_d : 3'd0;
    sym_start_d = (state_d == PLAY) && (addr_d == '0);
    done_d      = (state_q == DRAIN) && (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      chip_q      <= '0;
      addr_q      <= '0;
      sym_q       <= '0;
      stop_pend_q <= 1'b0;
      drn_q       <= '0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      sym_idx_q   <= '0;
      sym_start_q <= 1'b0;
      sop_q       <= 1'b0;
      done_q      <= 1'b0;
      vld_sr_q    <= '0;
    end else begin
      state_q     <= state_d;
      chip_q      <= chip_d;
      addr_q      <= addr_d;
      sym_q       <= sym_d;
      stop_pend_q <= stop_pend_d;
      drn_q       <= drn_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      sym_idx_q   <= sym_idx_d;
      sym_start_q <= sym_start_d;
      sop_q       <= (chip_d == SOP_AT);
      done_q      <= done_d;
      vld_sr_q[0] <= rd_en_q;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_sr_q[i] <= vld_sr_q[i-1];
      end
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign rd_en_o     = rd_en_q;
  assign rd_addr_o   = rd_addr_q;
  assign vld_o       = vld_sr_q[RD_LAT-1];
  assign sym_idx_o   = sym_idx_q;
  assign sym_start_o = sym_start_q;
  assign sop_o       = sop_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_cpri_rom_play_ctrl.sv
// Scoreboard bench for cpri_rom_play_ctrl: a cycle-level playback model
// queues expected reads/valids/symbol starts/done; a monitor pops them.
module tb_cpri_rom_play_ctrl;

  localparam int SL  = 8;
  localparam int SP  = 3;
  localparam int ACT = 1;
  localparam int CL  = 4;
  localparam int SOP = 3;
  localparam int RL  = 2;
  localparam int ADW = 16;
`ifdef CPRI_PLAY_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic           clk;
  logic           rst_n;
  logic           start_i;
  logic           stop_i;
  logic           busy_o;
  logic           rd_en_o;
  logic [ADW-1:0] rd_addr_o;
  logic           vld_o;
  logic [2:0]     sym_idx_o;
  logic           sym_start_o;
  logic           sop_o;
  logic           done_o;

  cpri_rom_play_ctrl #(
    .ADDR_DW(ADW), .SYM_LEN(SL), .SYM_PERIOD(SP), .ACT_SYM(ACT),
    .CHIP_LEN(CL), .SOP_OFS(SOP), .RD_LAT(RL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .stop_i(stop_i),
    .busy_o(busy_o), .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o),
    .vld_o(vld_o), .sym_idx_o(sym_idx_o), .sym_start_o(sym_start_o),
    .sop_o(sop_o), .done_o(done_o)
  );

  typedef struct {
    int c;
    int v;
  } ev_t;

  ev_t rd_q[$];
  ev_t vld_q[$];
  ev_t sym_q[$];
  ev_t done_q[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cycles since the last reset edge; the chip grid starts at 0 with it
  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;
  end

  function automatic void chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endfunction

  function automatic void bad(string nm, int at);
    checks++;
    errors++;
    $display("FAIL %s: event cycle %0d, now cycle %0d", nm, at, cyc);
  endfunction

  // First PLAY cycle after a start sampled in cycle c
  function automatic int play_at(int c);
    int p;
    p = c + 2;
    while (p % CL != 0) p++;
    return p;
  endfunction

  // Expected playback for a start in cycle c and stop in cycle sc
  // (sc < 0: no stop). Returns the done cycle, or -1 for none.
  function automatic int plan(int c, int sc);
    int p, l1, last, off;
    p = play_at(c);
    if (sc >= 0 && sc < p) return -1;
    l1 = p + SL * SP - 1;
    last = l1;
    if (sc >= p && (LOOP || sc <= l1))
      last = p + ((sc - p) / SL + 1) * SL - 1;
    for (int t = p; t <= last; t++) begin
      off = t - p;
      if (off % SL == 0)
        sym_q.push_back('{t, (off / SL) % SP});
      if ((off / SL) % SP < ACT) begin
        rd_q.push_back('{t, off % SL});
        vld_q.push_back('{t + RL, 0});
      end
    end
    done_q.push_back('{last + RL + 1, 0});
    return last + RL + 1;
  endfunction

  always @(negedge clk) begin
    ev_t e;
    if (rst_n) begin
      chk("sop", int'(sop_o), int'(cyc % CL == SOP));
      while (rd_q.size() > 0 && rd_q[0].c < cyc) begin
        bad("rd_missing", rd_q[0].c);
        void'(rd_q.pop_front());
      end
      while (vld_q.size() > 0 && vld_q[0].c < cyc) begin
        bad("vld_missing", vld_q[0].c);
        void'(vld_q.pop_front());
      end
      while (sym_q.size() > 0 && sym_q[0].c < cyc) begin
        bad("sym_missing", sym_q[0].c);
        void'(sym_q.pop_front());
      end
      while (done_q.size() > 0 && done_q[0].c < cyc) begin
        bad("done_missing", done_q[0].c);
        void'(done_q.pop_front());
      end
      if (rd_en_o) begin
        if (rd_q.size() == 0) bad("rd_unexpected", cyc);
        else begin
          e = rd_q.pop_front();
          chk("rd_cycle", cyc, e.c);
          chk("rd_addr", int'(rd_addr_o), e.v);
        end
      end else begin
        chk("rd_addr_idle", int'(rd_addr_o), 0);
      end
      if (vld_o) begin
        if (vld_q.size() == 0) bad("vld_unexpected", cyc);
        else begin
          e = vld_q.pop_front();
          chk("vld_cycle", cyc, e.c);
        end
      end
      if (sym_start_o) begin
        if (sym_q.size() == 0) bad("sym_unexpected", cyc);
        else begin
          e = sym_q.pop_front();
          chk("sym_cycle", cyc, e.c);
          chk("sym_idx", int'(sym_idx_o), e.v);
        end
      end
      if (done_o) begin
        if (done_q.size() == 0) bad("done_unexpected", cyc);
        else begin
          e = done_q.pop_front();
          chk("done_cycle", cyc, e.c);
          chk("done_busy", int'(busy_o), 0);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // mode: -1 no stop, 0 stop with start, 1 stop in ALIGN, 2 stop at p+off
  task automatic run(input int mode, input int off);
    int c, p, sc, dn, endc;
    c = cyc;
    p = play_at(c);
    sc = -1;
    if (mode == 0) sc = c;
    else if (mode == 1) sc = c + 1;
    else if (mode == 2) sc = p + off;
    dn = plan(c, sc);
    start_i = 1'b1;
    stop_i = (sc == c);
    step();
    start_i = 1'b0;
    stop_i = 1'b0;
    chk("busy_rise", int'(busy_o), int'(sc != c));
    endc = ((dn >= 0) ? dn : p) + 3;
    if (sc + 2 > endc) endc = sc + 2;
    while (cyc < endc) begin
      stop_i = (cyc == sc);
      step();
      stop_i = 1'b0;
      if (sc > c && sc < p && cyc == sc + 1)
        chk("align_stop_idle", int'(busy_o), 0);
    end
    chk("queues_drained",
        rd_q.size() + vld_q.size() + sym_q.size() + done_q.size(), 0);
    chk("idle_at_end", int'(busy_o), 0);
  endtask

  task automatic reset_mid_play();
    int n, dn;
    dn = plan(cyc, -1);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    n = 0;
    while (!(rd_en_o && rd_addr_o == 5) && n < 60) begin
      step();
      n++;
    end
    chk("reach_addr5", int'(rd_addr_o), 5);
    rst_n = 1'b0;
    rd_q.delete();
    vld_q.delete();
    sym_q.delete();
    done_q.delete();
    step();
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_rd_en", int'(rd_en_o), 0);
    chk("rst_rd_addr", int'(rd_addr_o), 0);
    chk("rst_vld", int'(vld_o), 0);
    chk("rst_sym_idx", int'(sym_idx_o), 0);
    chk("rst_sym_start", int'(sym_start_o), 0);
    chk("rst_sop", int'(sop_o), 0);
    chk("rst_done", int'(done_o), 0);
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    int mode, off;
    rst_n = 1'b0;
    start_i = 1'b0;
    stop_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;
    repeat (12) begin
      step();
      chk("rst_idle_busy", int'(busy_o), 0);
    end
    while (cyc % CL != 1) step();
    if (LOOP) run(2, 3 * SL * SP + 3);
    else run(-1, 0);
    run(0, 0);
    run(1, 0);
    run(2, 3);
    reset_mid_play();
    if (LOOP) run(2, 5);
    else run(-1, 0);
    repeat (20) begin
      repeat ($urandom_range(0, 5)) step();
      if (LOOP) begin
        mode = 2;
        off = $urandom_range(0, 3 * SL * SP);
      end else begin
        mode = $urandom_range(0, 3) - 1;
        off = $urandom_range(0, SL * SP + 3);
      end
      run(mode, off);
    end
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpri_rom_play_ctrl.md
# cpri_rom_play_ctrl

Playback sequencer for the CPRI test-pattern ROM bank. On command it aligns to the chip grid, walks the ROM address across active symbols of a symbol period, and flags which read cycles carry valid data. It also provides the CPRI SOP strobe and a drain/done handshake. It sits between the test control registers and the eight 64-bit pattern ROMs that drive the CPRI lanes.

## Interface
- ADDR_DW, 16, ROM address width
- SYM_LEN, 12672, ROM words per symbol
- SYM_PERIOD, 5, symbols per period (max 8)
- ACT_SYM, 1, leading symbols of each period that read the ROM (1..SYM_PERIOD)
- CHIP_LEN, 96, chip-grid period in cycles
- SOP_OFS, 3, chip count at which sop_o fires (< CHIP_LEN)
- RD_LAT, 2, ROM read plus output-register latency in cycles (≥1)

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active-low
- start_i  in  1  one-cycle start command
- stop_i  in  1  one-cycle graceful stop command
- busy_o  out  1  high in any state except IDLE
- rd_en_o  out  1  ROM read enable
- rd_addr_o  out  ADDR_DW  ROM address, 0 when rd_en_o is low
- vld_o  out  1  rd_en_o delayed RD_LAT cycles; marks valid lane data
- sym_idx_o  out  3  current symbol index in PLAY, 0 otherwise
- sym_start_o  out  1  pulse on the first cycle of each symbol in PLAY
- sop_o  out  1  chip-grid SOP strobe
- done_o  out  1  one-cycle pulse when playback fully drained

## Operation
- Reset: all outputs 0, state IDLE, chip_cnt 0, addr_cnt 0, sym_cnt 0, vld pipeline cleared.
- chip_cnt runs freely 0..CHIP_LEN-1 and wraps. It is independent of state. sop_o = (chip_cnt == SOP_OFS).
- States:
  - IDLE: on start_i go to ALIGN. If start_i and stop_i are asserted together, stop wins and the block stays IDLE.
  - ALIGN: wait for chip_cnt == CHIP_LEN-1, then go to PLAY with addr_cnt = 0 and sym_cnt = 0. A stop_i in ALIGN returns to IDLE with no reads issued and no done_o.
  - PLAY: addr_cnt counts 0..SYM_LEN-1. On wrap, sym_cnt increments 0..SYM_PERIOD-1.
    - rd_en_o = (sym_cnt < ACT_SYM).
    - rd_addr_o = addr_cnt when rd_en_o is high, else 0.
    - sym_start_o when addr_cnt == 0.
    - Period end (sym_cnt = SYM_PERIOD-1, addr_cnt = SYM_LEN-1): see Configuration.
  - DRAIN: rd_en_o is 0. Hold for RD_LAT cycles, then go to IDLE and pulse done_o on the IDLE-entry cycle.
- stop_i in PLAY is latched (stop_pend). The current symbol completes, then the block goes to DRAIN. This does not wait for the period end.
- start_i in any non-IDLE state is ignored.
- Counters use full-width compare, with no reliance on overflow. addr_cnt never exceeds SYM_LEN-1.
- Deasserting rst_n mid-playback aborts immediately. No done_o is issued and vld_o drops on the next cycle.

## Timing
- start_i at cycle T (IDLE) → busy_o at T+1.
- First rd_en_o occurs on the cycle with chip_cnt == 0 after ALIGN. Worst-case start-to-first-read is CHIP_LEN+1 cycles.
- Outputs rd_en_o, rd_addr_o, sym_idx_o and sym_start_o are registered and mutually aligned.
- vld_o is exactly RD_LAT cycles behind rd_en_o.
- Last vld_o occurs in the final DRAIN cycle. done_o follows one cycle later, and busy_o falls in the same cycle as done_o.
- sop_o first fires SOP_OFS cycles after the first clock edge with rst_n high.

## Configuration
- CPRI_PLAY_LOOP_EN defined: at period end, wrap to sym_cnt 0 and addr_cnt 0 and keep playing. Exit is only via stop_i.
- CPRI_PLAY_LOOP_EN undefined: one-shot. At period end go to DRAIN, then IDLE with done_o.
- In both builds, stop_i behaves identically.

## Test plan
Bench parameters: SYM_LEN=8, SYM_PERIOD=3, ACT_SYM=1, CHIP_LEN=4, SOP_OFS=3, RD_LAT=2.
- Reset release → sop_o at cycles 3, 7, 11; all other outputs 0; busy_o 0.
- One-shot (macro off): start_i at chip_cnt 1 → rd_en_o is 8 cycles with addresses 0..7 starting at chip_cnt 0, then 16 idle PLAY cycles, then DRAIN 2 cycles, then done_o; vld_o pulses 8 cycles, lagging by 2.
- Loop (macro on): start_i, let 3 periods elapse → rd_addr_o sequence 0..7 repeats every 24 cycles; done_o never fires; stop_i at PLAY addr 3 of sym 0 → reads 4..7 complete, DRAIN, done_o.
- start_i and stop_i in the same IDLE cycle → busy_o stays 0, no rd_en_o.
- stop_i during ALIGN → IDLE next cycle, no reads, no done_o.
- rst_n low at rd_addr_o = 5 → next cycle all outputs 0; a later start_i restarts from address 0.
